// File: rtl/axi_fsrc_sequencer_ctrl.sv
// FSRC TX sequencer run-time engine: start -> optional trigger wait -> delay
// -> GPIO update -> fixed-length trigger phase with per-channel pulses.
module axi_fsrc_sequencer_ctrl #(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4,
    parameter int DELAY_WIDTH   = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              seq_en,
    input  logic                              seq_start,
    input  logic                              ext_trig_en,
    input  logic                              ext_trig,
    input  logic                              non_fsrc_delay_en,
    input  logic [DELAY_WIDTH-1:0]            gpio_change_cnt,
    input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] first_trig_cnt,
    input  logic [COUNTER_WIDTH-1:0]          tx_accum_reset_cnt,
    input  logic [CTRL_WIDTH-1:0]             gpio_w,
    output logic [CTRL_WIDTH-1:0]             gpio_out,
    output logic [NUM_TRIG-1:0]               trig_out,
    output logic                              tx_accum_reset,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, TRIG, DONE} state_t;

    localparam int KW = NUM_TRIG * COUNTER_WIDTH;

    state_t                   state_q;
    logic [DELAY_WIDTH-1:0]   dcnt_q;
    logic [COUNTER_WIDTH-1:0] phase_q;
    logic [DELAY_WIDTH-1:0]   len_q;
    logic [KW-1:0]            k_q;
    logic [COUNTER_WIDTH-1:0] acc_q;
    logic [CTRL_WIDTH-1:0]    gpio_w_q;
    logic                     den_q;
    logic                     start_prev_q;
    logic                     ext_prev_q;
    logic [CTRL_WIDTH-1:0]    gpio_out_q;
    logic [NUM_TRIG-1:0]      trig_out_q;
    logic                     accum_q;
    logic                     busy_q;
    logic                     done_q;

    logic                     start_edge;
    logic                     ext_edge;
    logic [DELAY_WIDTH-1:0]   in_len;
    logic [COUNTER_WIDTH-1:0] phase_inc;

    assign start_edge = seq_start & ~start_prev_q;
    assign ext_edge   = ext_trig & ~ext_prev_q;
    // A zero delay count still costs one DELAY cycle when the stage is enabled
    assign in_len     = (gpio_change_cnt == '0) ? DELAY_WIDTH'(1)
                                                : gpio_change_cnt;
    assign phase_inc  = phase_q + COUNTER_WIDTH'(1);

    function automatic logic [NUM_TRIG-1:0] hits(
        input logic [COUNTER_WIDTH-1:0] p,
        input logic [KW-1:0]            k
    );
        logic [NUM_TRIG-1:0] h;
        h = '0;
        for (int i = 0; i < NUM_TRIG; i++)
            h[i] = (k[i*COUNTER_WIDTH +: COUNTER_WIDTH] == p);
        return h;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dcnt_q       <= '0;
            phase_q      <= '0;
            len_q        <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            gpio_w_q     <= '0;
            den_q        <= 1'b0;
            start_prev_q <= 1'b0;
            ext_prev_q   <= 1'b0;
            gpio_out_q   <= '0;
            trig_out_q   <= '0;
            accum_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            start_prev_q <= seq_start;
            ext_prev_q   <= ext_trig;
            trig_out_q   <= '0;
            accum_q      <= 1'b0;
            done_q       <= 1'b0;
            if (!seq_en) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_edge) begin
                            len_q    <= in_len;
                            k_q      <= first_trig_cnt;
                            acc_q    <= tx_accum_reset_cnt;
                            gpio_w_q <= gpio_w;
                            den_q    <= non_fsrc_delay_en;
                            busy_q   <= 1'b1;
                            if (ext_trig_en) begin
                                state_q <= ARMED;
                            end else if (non_fsrc_delay_en) begin
                                state_q <= DELAY;
                                dcnt_q  <= in_len;
                            end else begin
                                state_q    <= TRIG;
                                phase_q    <= '0;
                                gpio_out_q <= gpio_w;
                                trig_out_q <= hits('0, first_trig_cnt);
                                accum_q    <= (tx_accum_reset_cnt == '0);
                            end
                        end
                    end
                    ARMED: begin
                        if (ext_edge) begin
                            if (den_q) begin
                                state_q <= DELAY;
                                dcnt_q  <= len_q;
                            end else begin
                                state_q    <= TRIG;
                                phase_q    <= '0;
                                gpio_out_q <= gpio_w_q;
                                trig_out_q <= hits('0, k_q);
                                accum_q    <= (acc_q == '0);
                            end
                        end
                    end
                    DELAY: begin
                        if (dcnt_q == DELAY_WIDTH'(1)) begin
                            state_q    <= TRIG;
                            phase_q    <= '0;
                            gpio_out_q <= gpio_w_q;
                            trig_out_q <= hits('0, k_q);
                            accum_q    <= (acc_q == '0);
                        end else begin
                            dcnt_q <= dcnt_q - DELAY_WIDTH'(1);
                        end
                    end
                    TRIG: begin
                        if (&phase_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            phase_q    <= phase_inc;
                            trig_out_q <= hits(phase_inc, k_q);
                            accum_q    <= (acc_q == phase_inc);
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign gpio_out       = gpio_out_q;
    assign trig_out       = trig_out_q;
    assign tx_accum_reset = accum_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
